load64_stream: RTL and testbench
================================

# load64_stream

Byte-serial to 64-bit lane packer for the Keccak datapath. It is the load side of the 64-bit store byte-ordering function. It takes one message byte per handshake, places bytes little-endian into a 64-bit lane (first byte in bits [7:0]), and presents each finished lane to the absorb stage with a lane index inside the sponge rate. Short final lanes are zero-filled and flagged, so the padding logic downstream can act on them.

## Interface

Parameters:
- BW_DATA, 64, lane width; fixed at 64 (8 bytes per lane).
- RATE_LANES, 21, lanes per rate block (21 = SHAKE128, 17 = SHAKE256/SHA3-256).

Ports:
- i_clk  input  1  clock; every register updates on the rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_byte  input  8  message byte.
- i_byte_valid  input  1  i_byte is valid.
- i_byte_last  input  1  i_byte is the final byte of the message; qualified by i_byte_valid.
- o_byte_ready  output  1  packer accepts a byte this cycle.
- o_lane  output  BW_DATA  packed lane.
- o_lane_valid  output  1  o_lane and its sideband are valid.
- i_lane_ready  input  1  downstream accepts the lane.
- o_lane_idx  output  5  lane position in the rate block, 0..RATE_LANES-1.
- o_lane_nbytes  output  4  number of valid bytes in o_lane, 1..8.
- o_lane_last  output  1  lane holds the final message byte.
- o_block_end  output  1  o_lane_idx == RATE_LANES-1.

## Operation

- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Byte handshake: a byte is accepted when i_byte_valid & o_byte_ready. Lane handshake: a lane is accepted when o_lane_valid & i_lane_ready.
- States:
  - FILL: o_byte_ready=1, o_lane_valid=0.
  - HOLD: o_byte_ready=0, o_lane_valid=1.
- Byte counter bcnt (0..7), FILL only. An accepted byte is written to buf[8*bcnt+7 -: 8] and bcnt increments.
- FILL→HOLD on an accepted byte when bcnt==7 or i_byte_last=1.
  - o_lane_nbytes latches bcnt+1.
  - o_lane_last latches i_byte_last.
  - Bytes not written stay 0 (buf is cleared on each entry to FILL).
- HOLD→FILL on a lane handshake. On that transition:
  - buf=0 and bcnt=0.
  - If o_lane_last=1, lane_idx=0 (a new message starts a new block).
  - Else if lane_idx==RATE_LANES-1, lane_idx=0.
  - Else lane_idx+1.
- HOLD holds o_lane, o_lane_idx, o_lane_nbytes, o_lane_last and o_block_end stable until the handshake. i_byte_* is ignored in HOLD.
- Simultaneous events: last byte with bcnt==7 gives one lane with nbytes=8 and last=1. No extra empty lane is produced.
- Zero-length message is not supported: i_byte_last must come with a valid byte.
- o_block_end is combinational from the registered lane_idx. It can be high together with o_lane_last.
- Reset, including mid-lane or mid-block:
  - State=FILL, bcnt=0, buf=0, lane_idx=0.
  - Outputs: o_byte_ready=1 (the cycle after reset deasserts), o_lane_valid=0, o_lane=0, o_lane_idx=0, o_lane_nbytes=0, o_lane_last=0, o_block_end=0 (because lane_idx=0 and RATE_LANES>1).
  - Partial lane content is discarded.

## Timing

- o_lane_valid rises in the cycle after the completing byte is accepted (1-cycle latency).
- With i_byte_valid and i_lane_ready held high, one full lane takes 9 cycles: 8 byte cycles plus 1 HOLD cycle.
- o_byte_ready returns high in the cycle after the lane handshake. No byte is accepted in the handshake cycle.
- o_byte_ready depends only on state. There is no combinational path from i_lane_ready to o_byte_ready.
- All outputs are registered except o_byte_ready and o_block_end, which are decoded from registered state.

## Test plan

- Full lane: bytes 0x01..0x08 with i_lane_ready=1. Required: o_lane=0x0807060504030201, nbytes=8, idx=0, last=0, valid high for exactly 1 cycle.
- Short final lane: after one full lane, send 0xAA, 0xBB, 0xCC with last on 0xCC. Required: o_lane=0x0000000000CCBBAA, nbytes=3, idx=1, last=1. The next message's first lane has idx=0.
- Block wrap: 22 full lanes with RATE_LANES=21. Required: block_end=1 only on idx=20, and the 22nd lane has idx=0.
- Backpressure: i_lane_ready=0 for 5 cycles after a lane completes while bytes keep being offered. Required: o_byte_ready=0, all lane outputs stable, no byte consumed, lane accepted on the first ready cycle.
- Last on 8th byte: bytes 0x10..0x17 with last on 0x17. Required: a single lane 0x1716151413121110, nbytes=8, last=1, and no following empty lane.
- Mid-lane reset: 4 bytes accepted, then i_rst for 1 cycle. Required: all outputs at reset values. Then 0x21..0x28 yields 0x2827262524232221 with idx=0.

Source files
------------

// File: rtl/load64_stream.sv
// Byte-serial to 64-bit lane packer feeding the Keccak absorb stage.
// Bytes are packed little-endian; each finished lane carries its index inside the sponge rate.
module load64_stream #(
    parameter int BW_DATA    = 64,
    parameter int RATE_LANES = 21
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_byte,
    input  logic               i_byte_valid,
    input  logic               i_byte_last,
    output logic               o_byte_ready,
    output logic [BW_DATA-1:0] o_lane,
    output logic               o_lane_valid,
    input  logic               i_lane_ready,
    output logic [4:0]         o_lane_idx,
    output logic [3:0]         o_lane_nbytes,
    output logic               o_lane_last,
    output logic               o_block_end
);

    localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state;
    logic [2:0]         bcnt;
    logic [BW_DATA-1:0] lane_buf;
    logic [4:0]         lane_idx;
    logic [3:0]         lane_nbytes;
    logic               lane_last;
    logic               lane_valid;

    // The packing buffer doubles as the registered lane output, so HOLD keeps it stable for free.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= FILL;
            bcnt        <= 3'd0;
            lane_buf    <= '0;
            lane_idx    <= 5'd0;
            lane_nbytes <= 4'd0;
            lane_last   <= 1'b0;
            lane_valid  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (i_byte_valid) begin
                        lane_buf[{bcnt, 3'b000} +: 8] <= i_byte;
                        if (bcnt == 3'd7 || i_byte_last) begin
                            state       <= HOLD;
                            lane_valid  <= 1'b1;
                            lane_nbytes <= {1'b0, bcnt} + 4'd1;
                            lane_last   <= i_byte_last;
                        end else begin
                            bcnt <= bcnt + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (i_lane_ready) begin
                        state      <= FILL;
                        lane_valid <= 1'b0;
                        lane_buf   <= '0;
                        bcnt       <= 3'd0;
                        // A finished message always restarts at the head of a fresh rate block.
                        if (lane_last || lane_idx == LAST_IDX) begin
                            lane_idx <= 5'd0;
                        end else begin
                            lane_idx <= lane_idx + 5'd1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign o_byte_ready  = (state == FILL);
    assign o_lane        = lane_buf;
    assign o_lane_valid  = lane_valid;
    assign o_lane_idx    = lane_idx;
    assign o_lane_nbytes = lane_nbytes;
    assign o_lane_last   = lane_last;
    assign o_block_end   = (lane_idx == LAST_IDX);

endmodule

// File: tb/tb_load64_stream.sv
// Self-checking bench for load64_stream: random handshakes against a message-level lane model.
// Expected lanes are derived by chopping each message into 8-byte little-endian chunks.
module tb_load64_stream;

    localparam int RATE = 21;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        i_byte_last;
    logic        o_byte_ready;
    logic [63:0] o_lane;
    logic        o_lane_valid;
    logic        i_lane_ready;
    logic [4:0]  o_lane_idx;
    logic [3:0]  o_lane_nbytes;
    logic        o_lane_last;
    logic        o_block_end;

    always #5 i_clk = ~i_clk;

    load64_stream #(.BW_DATA(64), .RATE_LANES(RATE)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .i_byte_last  (i_byte_last),
        .o_byte_ready (o_byte_ready),
        .o_lane       (o_lane),
        .o_lane_valid (o_lane_valid),
        .i_lane_ready (i_lane_ready),
        .o_lane_idx   (o_lane_idx),
        .o_lane_nbytes(o_lane_nbytes),
        .o_lane_last  (o_lane_last),
        .o_block_end  (o_block_end)
    );

    typedef struct packed {
        logic [63:0] lane;
        logic [4:0]  idx;
        logic [3:0]  nbytes;
        logic        last;
    } lane_t;

    logic [8:0] byte_q[$];
    lane_t      exp_q[$];
    int         cur_idx = 0;
    int         checks = 0;
    int         passes = 0;
    int         fails = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Queue a message (or a lane-aligned message prefix) and the lanes it must produce.
    task automatic addMessage(input int len, input bit with_last, input int base, input int step);
        logic [7:0] b[$];
        for (int i = 0; i < len; i++) begin
            b.push_back(base < 0 ? 8'($urandom) : 8'(base + i * step));
            byte_q.push_back({with_last && (i == len - 1), b[i]});
        end
        for (int k = 0; k * 8 < len; k++) begin
            lane_t e;
            int    n;
            n = (len - 8 * k < 8) ? len - 8 * k : 8;
            e.lane = 64'd0;
            for (int j = 0; j < n; j++) e.lane = e.lane | (64'(b[8 * k + j]) << (8 * j));
            e.nbytes = 4'(n);
            e.last   = with_last && (8 * k + n == len);
            e.idx    = 5'(cur_idx);
            cur_idx  = e.last ? 0 : (cur_idx + 1) % RATE;
            exp_q.push_back(e);
        end
    endtask

    task automatic applyStimulus(input int vpct, input int rpct, input int stall, input int budget,
                                 output int cycles);
        int          stall_cnt = 0;
        bit          held = 0;
        bit          bv, lr;
        logic [63:0] h_lane;
        logic [4:0]  h_idx;
        logic [3:0]  h_nb;
        logic        h_last;
        lane_t       e;
        cycles = 0;
        while ((byte_q.size() != 0 || exp_q.size() != 0) && cycles < budget) begin
            @(negedge i_clk);
            cycles++;
            if (held) begin
                checkOutput("hold_valid", o_lane_valid, 1);
                checkOutput("hold_byte_ready", o_byte_ready, 0);
                checkOutput("hold_lane", o_lane, h_lane);
                checkOutput("hold_idx", o_lane_idx, h_idx);
                checkOutput("hold_nbytes", o_lane_nbytes, h_nb);
                checkOutput("hold_last", o_lane_last, h_last);
            end
            bv = (byte_q.size() != 0) && ($urandom_range(99) < vpct);
            lr = (stall_cnt >= stall) && ($urandom_range(99) < rpct);
            i_byte_valid = bv;
            i_byte       = bv ? byte_q[0][7:0] : 8'($urandom);
            i_byte_last  = bv ? byte_q[0][8] : 1'($urandom_range(1));
            i_lane_ready = lr;
            held = 0;
            if (o_lane_valid === 1'b1) begin
                if (!lr) begin
                    held   = 1;
                    h_lane = o_lane;
                    h_idx  = o_lane_idx;
                    h_nb   = o_lane_nbytes;
                    h_last = o_lane_last;
                    stall_cnt++;
                end else begin
                    checkOutput("lane_expected", 64'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        checkOutput("lane_data", o_lane, e.lane);
                        checkOutput("lane_idx", o_lane_idx, e.idx);
                        checkOutput("lane_nbytes", o_lane_nbytes, e.nbytes);
                        checkOutput("lane_last", o_lane_last, e.last);
                        checkOutput("block_end", o_block_end, 64'(e.idx == 5'(RATE - 1)));
                    end
                    stall_cnt = 0;
                end
            end
            if (o_byte_ready === 1'b1 && bv) void'(byte_q.pop_front());
        end
        @(negedge i_clk);
        i_byte_valid = 1'b0;
        i_byte_last  = 1'b0;
        i_lane_ready = 1'b0;
        checkOutput("drained", 64'(byte_q.size() + exp_q.size()), 0);
    endtask

    task automatic checkIdle(input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput("idle_valid", o_lane_valid, 0);
            checkOutput("idle_byte_ready", o_byte_ready, 1);
            @(negedge i_clk);
        end
    endtask

    task automatic checkReset(input string tag);
        $display("[TB] reset check: %s", tag);
        checkOutput("rst_byte_ready", o_byte_ready, 1);
        checkOutput("rst_lane_valid", o_lane_valid, 0);
        checkOutput("rst_lane", o_lane, 0);
        checkOutput("rst_idx", o_lane_idx, 0);
        checkOutput("rst_nbytes", o_lane_nbytes, 0);
        checkOutput("rst_last", o_lane_last, 0);
        checkOutput("rst_block_end", o_block_end, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        i_rst        = 1'b1;
        i_byte       = 8'd0;
        i_byte_valid = 1'b0;
        i_byte_last  = 1'b0;
        i_lane_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checkReset("power-on");
        i_rst = 1'b0;

        $display("[TB] full lane, short final lane, next message");
        addMessage(8, 0, 'h01, 1);
        addMessage(3, 1, 'hAA, 'h11);
        addMessage(5, 1, -1, 0);
        applyStimulus(100, 100, 0, 200, cyc);
        checkIdle(3);

        $display("[TB] throughput at full rate");
        addMessage(16, 1, 'h40, 1);
        applyStimulus(100, 100, 0, 200, cyc);
        checkOutput("throughput_cycles", 64'(cyc), 18);

        $display("[TB] last on 8th byte");
        addMessage(8, 1, 'h10, 1);
        applyStimulus(100, 100, 0, 200, cyc);
        checkIdle(4);

        $display("[TB] backpressure");
        addMessage(16, 1, 'h30, 1);
        applyStimulus(100, 100, 5, 200, cyc);

        $display("[TB] block wrap");
        addMessage(22 * 8, 1, -1, 0);
        applyStimulus(80, 80, 0, 2000, cyc);

        $display("[TB] mid-lane reset");
        addMessage(8, 0, -1, 0);
        applyStimulus(100, 100, 0, 200, cyc);
        for (int i = 0; i < 4; i++) begin
            i_byte_valid = 1'b1;
            i_byte       = 8'(8'hE0 + i);
            i_byte_last  = 1'b0;
            @(negedge i_clk);
        end
        i_byte_valid = 1'b0;
        i_rst        = 1'b1;
        @(negedge i_clk);
        i_rst   = 1'b0;
        cur_idx = 0;
        checkReset("mid-lane");
        addMessage(8, 1, 'h21, 1);
        applyStimulus(100, 100, 0, 200, cyc);

        $display("[TB] random messages");
        for (int t = 0; t < 6; t++) begin
            addMessage($urandom_range(1, 40), 1, -1, 0);
            applyStimulus(70, 60, $urandom_range(0, 3), 3000, cyc);
        end
        checkIdle(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
